// File: rtl/reg_cmd_ctrl_pkg.sv
// Shared opcodes, state encoding and default widths for the
// register-file command path.
package reg_cmd_ctrl_pkg;

    localparam int         DATAWIDTH_DEF  = 8;
    localparam int         ADDR_DEF       = 4;
    localparam logic [7:0] WR_CMD_DEF     = 8'hAA;
    localparam logic [7:0] RD_CMD_DEF     = 8'hBB;
    localparam int         RD_TIMEOUT_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_STROBE,
        RD_ADDR,
        RD_WAIT,
        RD_SEND
    } state_t;

    // A one-cycle timeout still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_cmd_ctrl.sv
// Decodes write/read command frames from the RX byte stream and drives
// the register file bus; read results are forwarded to the TX FIFO.
module reg_cmd_ctrl
    import reg_cmd_ctrl_pkg::*;
#(
    parameter int                   DATAWIDTH  = DATAWIDTH_DEF,
    parameter int                   ADDR       = ADDR_DEF,
    parameter logic [DATAWIDTH-1:0] WR_CMD     = WR_CMD_DEF,
    parameter logic [DATAWIDTH-1:0] RD_CMD     = RD_CMD_DEF,
    parameter int                   RD_TIMEOUT = RD_TIMEOUT_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATAWIDTH-1:0] RX_P_DATA,
    input  logic                 RX_D_VLD,
    output logic [ADDR-1:0]      Address,
    output logic                 WrEn,
    output logic                 RdEn,
    output logic [DATAWIDTH-1:0] WrData,
    input  logic [DATAWIDTH-1:0] RdData,
    input  logic                 RdData_Valid,
    input  logic                 TX_FULL,
    output logic [DATAWIDTH-1:0] TX_P_DATA,
    output logic                 TX_D_VLD,
    output logic                 CMD_ERR
);

    localparam int            CW      = cnt_width(RD_TIMEOUT);
    localparam logic [CW-1:0] TO_LAST = CW'(RD_TIMEOUT - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR-1:0]      r_addr;
    logic [ADDR-1:0]      w_addr_nxt;
    logic [DATAWIDTH-1:0] r_wdata;
    logic [DATAWIDTH-1:0] w_wdata_nxt;
    logic [DATAWIDTH-1:0] r_tx;
    logic [DATAWIDTH-1:0] w_tx_nxt;
    logic                 r_wren;
    logic                 w_wren_nxt;
    logic                 r_rden;
    logic                 w_rden_nxt;
    logic                 r_txv;
    logic                 w_txv_nxt;
    logic                 r_err;
    logic                 w_err_nxt;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nxt;

    logic                 w_addr_ok;
    logic [ADDR-1:0]      w_rx_addr;

    assign w_addr_ok = (RX_P_DATA[DATAWIDTH-1:ADDR] == '0);
    assign w_rx_addr = RX_P_DATA[ADDR-1:0];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_tx    <= '0;
            r_wren  <= 1'b0;
            r_rden  <= 1'b0;
            r_txv   <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_tx    <= w_tx_nxt;
            r_wren  <= w_wren_nxt;
            r_rden  <= w_rden_nxt;
            r_txv   <= w_txv_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_tx_nxt    = r_tx;
        w_wren_nxt  = 1'b0;
        w_rden_nxt  = 1'b0;
        w_txv_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_cnt_nxt   = r_cnt;

        unique case (r_state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == WR_CMD) begin
                        w_state_nxt = WR_ADDR;
                    end else if (RX_P_DATA == RD_CMD) begin
                        w_state_nxt = RD_ADDR;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    if (!w_addr_ok) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_addr_nxt  = w_rx_addr;
                        w_state_nxt = WR_DATA;
                    end
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    w_wdata_nxt = RX_P_DATA;
                    w_wren_nxt  = 1'b1;
                    w_state_nxt = WR_STROBE;
                end
            end
            WR_STROBE: begin
                w_err_nxt   = RX_D_VLD;
                w_state_nxt = IDLE;
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    if (!w_addr_ok) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_addr_nxt  = w_rx_addr;
                        w_rden_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                w_err_nxt = RX_D_VLD;
                if (RdData_Valid) begin
                    w_tx_nxt    = RdData;
                    w_txv_nxt   = !TX_FULL;
                    w_state_nxt = RD_SEND;
                end else if (r_cnt == TO_LAST) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RD_SEND: begin
                // Stay here for the strobe cycle, then release.
                w_err_nxt = RX_D_VLD;
                if (r_txv) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_txv_nxt = !TX_FULL;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign Address   = r_addr;
    assign WrData    = r_wdata;
    assign WrEn      = r_wren;
    assign RdEn      = r_rden;
    assign TX_P_DATA = r_tx;
    assign TX_D_VLD  = r_txv;
    assign CMD_ERR   = r_err;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Bench for reg_cmd_ctrl: directed frames with literal expectations,
// then random frames against a frame-level reference model.
module tb_reg_cmd_ctrl;

    localparam int TO = 8;

    logic       CLK;
    logic       RST;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic [3:0] Address;
    logic       WrEn;
    logic       RdEn;
    logic [7:0] WrData;
    logic [7:0] RdData;
    logic       RdData_Valid;
    logic       TX_FULL;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       CMD_ERR;

    reg_cmd_ctrl dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
        .RdData(RdData), .RdData_Valid(RdData_Valid),
        .TX_FULL(TX_FULL), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .CMD_ERR(CMD_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] rf_rst(input int i);
        return (i == 2) ? 8'h21 : (i == 3) ? 8'h08 : 8'h00;
    endfunction

    // Behavioural register file with a programmable read latency.
    logic [7:0] rf [16];
    logic [3:0] rf_addr;
    int         rf_cnt;
    int         rf_lat = 1;
    logic       rf_mute = 1'b0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 16; i++) rf[i] <= rf_rst(i);
            rf_addr      <= '0;
            rf_cnt       <= 0;
            RdData_Valid <= 1'b0;
            RdData       <= '0;
        end else begin
            RdData_Valid <= 1'b0;
            if (WrEn) rf[Address] <= WrData;
            if (RdEn) begin
                rf_addr <= Address;
                rf_cnt  <= 0;
                if (rf_lat <= 1) begin
                    if (!rf_mute) begin
                        RdData_Valid <= 1'b1;
                        RdData       <= rf[Address];
                    end
                end else begin
                    rf_cnt <= rf_lat - 1;
                end
            end else if (rf_cnt != 0) begin
                if (rf_cnt == 1 && !rf_mute) begin
                    RdData_Valid <= 1'b1;
                    RdData       <= rf[rf_addr];
                end
                rf_cnt <= rf_cnt - 1;
            end
        end
    end

    // Reference model: what the next byte means, and expected outputs.
    localparam logic [2:0] M_OP = 3'd0, M_WA = 3'd1, M_WD = 3'd2,
                           M_WS = 3'd3, M_RA = 3'd4, M_RW = 3'd5,
                           M_TX = 3'd6;

    typedef struct packed {
        logic [2:0] ph;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] tx;
        logic       wren;
        logic       rden;
        logic       txv;
        logic       err;
        logic [3:0] waited;
    } mdl_t;

    mdl_t       m;
    logic [7:0] gold [16];

    function automatic mdl_t step(input mdl_t s, input logic v,
                                  input logic [7:0] b, input logic rv,
                                  input logic full, input logic [7:0] g);
        mdl_t n;
        n = s;
        n.wren = 1'b0;
        n.rden = 1'b0;
        n.txv  = 1'b0;
        n.err  = 1'b0;
        case (s.ph)
            M_OP: if (v) begin
                if (b == 8'hAA)      n.ph = M_WA;
                else if (b == 8'hBB) n.ph = M_RA;
                else                 n.err = 1'b1;
            end
            M_WA, M_RA: if (v) begin
                if (b > 8'd15) begin
                    n.err = 1'b1;
                    n.ph  = M_OP;
                end else begin
                    n.addr = b[3:0];
                    if (s.ph == M_WA) begin
                        n.ph = M_WD;
                    end else begin
                        n.rden   = 1'b1;
                        n.waited = 4'd0;
                        n.ph     = M_RW;
                    end
                end
            end
            M_WD: if (v) begin
                n.wdata = b;
                n.wren  = 1'b1;
                n.ph    = M_WS;
            end
            M_WS: begin
                n.err = v;
                n.ph  = M_OP;
            end
            M_RW: begin
                n.err = v;
                if (rv) begin
                    n.tx  = g;
                    n.txv = !full;
                    n.ph  = M_TX;
                end else if (s.waited == 4'(TO - 1)) begin
                    n.err = 1'b1;
                    n.ph  = M_OP;
                end else begin
                    n.waited = s.waited + 4'd1;
                end
            end
            M_TX: begin
                n.err = v;
                if (s.txv) n.ph = M_OP;
                else       n.txv = !full;
            end
            default: n.ph = M_OP;
        endcase
        return n;
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) m <= '0;
        else m <= step(m, RX_D_VLD, RX_P_DATA, RdData_Valid, TX_FULL,
                       gold[m.addr]);
    end

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 16; i++) gold[i] <= rf_rst(i);
        end else if (m.wren) begin
            gold[m.addr] <= m.wdata;
        end
    end

    always @(negedge CLK) begin
        if (RST) begin
            chk("Address", int'(Address), int'(m.addr));
            chk("WrData", int'(WrData), int'(m.wdata));
            chk("WrEn", int'(WrEn), int'(m.wren));
            chk("RdEn", int'(RdEn), int'(m.rden));
            chk("TX_P_DATA", int'(TX_P_DATA), int'(m.tx));
            chk("TX_D_VLD", int'(TX_D_VLD), int'(m.txv));
            chk("CMD_ERR", int'(CMD_ERR), int'(m.err));
            chk("wr_rd_excl", int'(WrEn & RdEn), 0);
        end
    end

    // Stimulus
    logic rnd_full = 1'b0;

    task automatic tick();
        @(negedge CLK);
        if (rnd_full) TX_FULL = ($urandom_range(0, 3) == 0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
        RX_P_DATA = 8'($urandom);
    endtask

    function automatic logic [7:0] rnd_addr();
        if ($urandom_range(0, 7) == 0) return 8'($urandom);
        return 8'($urandom_range(0, 15));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s;
        int k;
        RST = 1'b0;
        RX_P_DATA = '0;
        RX_D_VLD = 1'b0;
        TX_FULL = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_Address", int'(Address), 0);
        chk("rst_WrData", int'(WrData), 0);
        chk("rst_TX_P_DATA", int'(TX_P_DATA), 0);
        chk("rst_strobes", int'({WrEn, RdEn, TX_D_VLD, CMD_ERR}), 0);
        RST = 1'b1;
        idle(2);

        // Read after reset: reg 2 holds 0x21
        send(8'hBB);
        send(8'h02);
        chk("rd_RdEn", int'(RdEn), 1);
        chk("rd_Address", int'(Address), 2);
        idle(2);
        chk("rd_TX_D_VLD", int'(TX_D_VLD), 1);
        chk("rd_TX_P_DATA", int'(TX_P_DATA), 'h21);
        chk("model_tx", int'(m.tx), 'h21);
        idle(3);

        // Write 0x3C to reg 5, then read it back
        send(8'hAA);
        send(8'h05);
        send(8'h3C);
        chk("wr_WrEn", int'(WrEn), 1);
        chk("wr_Address", int'(Address), 5);
        chk("wr_WrData", int'(WrData), 'h3C);
        chk("model_wren", int'(m.wren), 1);
        idle(2);
        send(8'hBB);
        send(8'h05);
        idle(2);
        chk("rb_TX_D_VLD", int'(TX_D_VLD), 1);
        chk("rb_TX_P_DATA", int'(TX_P_DATA), 'h3C);
        idle(3);

        // Back-pressure on reg 3
        TX_FULL = 1'b1;
        send(8'hBB);
        send(8'h03);
        s = 0;
        repeat (5) begin
            @(negedge CLK);
            s += int'(TX_D_VLD);
        end
        chk("bp_no_push", s, 0);
        chk("bp_hold_data", int'(TX_P_DATA), 'h08);
        TX_FULL = 1'b0;
        s = 0;
        repeat (5) begin
            @(negedge CLK);
            s += int'(TX_D_VLD);
        end
        chk("bp_one_push", s, 1);
        chk("bp_data", int'(TX_P_DATA), 'h08);

        // Bad opcode
        send(8'h55);
        chk("op_err", int'(CMD_ERR), 1);
        chk("model_err", int'(m.err), 1);
        s = int'(WrEn) + int'(RdEn);
        repeat (4) begin
            @(negedge CLK);
            s += int'(WrEn) + int'(RdEn);
        end
        chk("op_no_access", s, 0);

        // Out-of-range write address
        send(8'hAA);
        send(8'h13);
        chk("addr_err", int'(CMD_ERR), 1);
        s = 0;
        repeat (5) begin
            @(negedge CLK);
            s += int'(WrEn);
        end
        chk("addr_no_write", s, 0);

        // Read timeout
        rf_mute = 1'b1;
        send(8'hBB);
        send(8'h01);
        chk("to_RdEn", int'(RdEn), 1);
        s = 0;
        repeat (7) begin
            @(negedge CLK);
            s += int'(CMD_ERR);
        end
        chk("to_early_err", s, 0);
        @(negedge CLK);
        chk("to_err", int'(CMD_ERR), 1);
        rf_mute = 1'b0;
        send(8'hBB);
        send(8'h02);
        idle(2);
        chk("to_recover", int'(TX_P_DATA), 'h21);
        idle(3);

        // Back-to-back write then read of the same register
        send(8'hAA);
        send(8'h01);
        send(8'h11);
        chk("b2b_WrEn", int'(WrEn), 1);
        chk("b2b_WrData", int'(WrData), 'h11);
        idle(1);
        send(8'hBB);
        send(8'h01);
        idle(2);
        chk("b2b_TX_D_VLD", int'(TX_D_VLD), 1);
        chk("b2b_TX_P_DATA", int'(TX_P_DATA), 'h11);
        idle(3);

        // Reset mid-frame
        send(8'hAA);
        send(8'h07);
        RST = 1'b0;
        #1;
        chk("mr_Address", int'(Address), 0);
        chk("mr_WrData", int'(WrData), 0);
        chk("mr_TX_P_DATA", int'(TX_P_DATA), 0);
        chk("mr_strobes", int'({WrEn, RdEn, TX_D_VLD, CMD_ERR}), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        idle(2);
        send(8'h44);
        chk("mr_err", int'(CMD_ERR), 1);
        s = 0;
        repeat (6) begin
            @(negedge CLK);
            s += int'(WrEn);
        end
        chk("mr_no_write", s, 0);

        // Random frames, random gaps, latency and back-pressure
        rnd_full = 1'b1;
        for (int f = 0; f < 300; f++) begin
            k = $urandom_range(0, 9);
            rf_lat = $urandom_range(1, 9);
            if (k < 4) begin
                send(8'hAA);
                idle($urandom_range(0, 2));
                send(rnd_addr());
                idle($urandom_range(0, 2));
                send(8'($urandom));
            end else if (k < 8) begin
                send(8'hBB);
                idle($urandom_range(0, 2));
                send(rnd_addr());
            end else begin
                send(8'($urandom));
            end
            idle($urandom_range(0, 14));
        end
        rnd_full = 1'b0;
        TX_FULL = 1'b0;
        idle(30);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
